// File: rtl/result_display.sv
// Captures a 6-bit result and sign on load, converts to BCD (7 cycles load-to-display) and scans a 4-digit 7-seg.
// No backpressure: load is taken only while idle (busy=0); a load during conversion is dropped.
module result_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] y6,
    input  logic       neg,
    input  logic       load,
    output logic       busy,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;

    state_t        state, state_nxt;
    logic [13:0]   sr;          // {tens, ones, binary} double-dabble register
    logic [13:0]   sr_shift;
    logic [7:0]    bcd_adj;
    logic [2:0]    bit_cnt;
    logic          neg_cap;
    logic [3:0]    ones, tens;
    logic          minus;
    logic [CW-1:0] scan_cnt;
    logic [1:0]    idx;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = CONV;
            CONV:    if (bit_cnt == 3'd5) state_nxt = LATCH;
            LATCH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_comb begin
        bcd_adj = sr[13:6];
        if (sr[9:6] >= 4'd5)   bcd_adj[3:0] = sr[9:6] + 4'd3;
        if (sr[13:10] >= 4'd5) bcd_adj[7:4] = sr[13:10] + 4'd3;
        sr_shift = {bcd_adj, sr[5:0]} << 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr      <= '0;
            bit_cnt <= '0;
            neg_cap <= 1'b0;
            ones    <= '0;
            tens    <= '0;
            minus   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (load) begin
                    sr      <= {8'd0, y6};
                    neg_cap <= neg;
                    bit_cnt <= '0;
                end
                CONV: begin
                    sr      <= sr_shift;
                    bit_cnt <= bit_cnt + 3'd1;
                end
                LATCH: begin
                    ones  <= sr[9:6];
                    tens  <= sr[13:10];
                    // A negative zero is shown as plain "0".
                    minus <= neg_cap && (sr[13:6] != 8'd0);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == CW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + CW'(1);
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    always_comb begin
        an = ~(4'b0001 << idx);
        dp = 1'b1;
        case (idx)
            2'd0:    seg = seg7(ones);
            2'd1:    seg = (tens == 4'd0) ? SEG_BLANK : seg7(tens);
            2'd2:    seg = minus ? SEG_MINUS : SEG_BLANK;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule
